dcache_miss_ctrl: RTL and testbench

Sequencing controller for the data-memory side of the pipelined core: it watches the MEM-stage access, and on a load miss refills one direct-mapped cache line from main memory word by word. Stores are write-through to main memory. While a memory transaction is outstanding it holds the pipeline through `Stall`, which feeds the stall/trigger path of the pipeline registers and control decode. It owns the main-memory request/response handshake and the cache data/tag write strobes; tag compare and data arrays live outside.

---
 rtl/dcache_miss_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_miss_ctrl
// Brief    : Data-cache miss/store sequencer. Write-through stores, word-by-
//            word line refill on load miss, pipeline stall and cache strobes.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_miss_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              MemReadM,
    input  logic                              MemWriteM,
    input  logic [ADDR_WIDTH-1:0]             AddrM,
    input  logic [31:0]                       WriteDataM,
    input  logic                              HitM,
    output logic                              Stall,
    output logic                              ValidClr,
    output logic                              RefillWE,
    output logic [$clog2(WORDS_PER_LINE)-1:0] RefillWordIdx,
    output logic                              TagWE,
    output logic                              MemReqValid,
    input  logic                              MemReqReady,
    output logic                              MemReqWE,
    output logic [ADDR_WIDTH-1:0]             MemReqAddr,
    output logic [31:0]                       MemReqData,
    input  logic                              MemRespValid,
    output logic [31:0]                       MissCount
);

    localparam int c_IDX_W = $clog2(WORDS_PER_LINE);
    // Byte offset within a line: word index plus two byte-select bits.
    localparam int c_OFF_W = c_IDX_W + 2;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_REQ   = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_IDX_W-1:0]    r_word_cnt;
    logic [c_IDX_W-1:0]    w_word_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [31:0]           r_data;
    logic [31:0]           w_data_nxt;
    logic [31:0]           r_miss_count;
    logic                  w_miss_inc;

    logic                  w_stall;
    logic                  w_valid_clr;
    logic                  w_refill_we;
    logic [c_IDX_W-1:0]    w_refill_idx;
    logic                  w_tag_we;
    logic                  w_req_valid;
    logic                  w_req_we;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [31:0]           w_req_data;

    // A store wins when both read and write are asserted.
    logic                  w_is_store;
    logic                  w_is_miss;
    logic [ADDR_WIDTH-1:0] w_line_addr;

    assign w_is_store  = MemWriteM;
    assign w_is_miss   = MemReadM & ~MemWriteM & ~HitM;
    assign w_line_addr = {AddrM[ADDR_WIDTH-1:c_OFF_W], {c_OFF_W{1'b0}}};

    // State, counter, latches and miss counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_word_cnt   <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_miss_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            if (w_miss_inc) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    // Next-state and strobe decode; IDLE looks at the live MEM-stage access.
    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_miss_inc     = 1'b0;
        w_stall        = 1'b0;
        w_valid_clr    = 1'b0;
        w_refill_we    = 1'b0;
        w_refill_idx   = '0;
        w_tag_we       = 1'b0;
        w_req_valid    = 1'b0;
        w_req_we       = 1'b0;
        w_req_addr     = '0;
        w_req_data     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_is_store) begin
                    w_req_valid = 1'b1;
                    w_req_we    = 1'b1;
                    w_req_addr  = AddrM;
                    w_req_data  = WriteDataM;
                    if (!MemReqReady) begin
                        w_stall     = 1'b1;
                        w_addr_nxt  = AddrM;
                        w_data_nxt  = WriteDataM;
                        w_state_nxt = S_WRITE;
                    end
                end else if (w_is_miss) begin
                    w_stall     = 1'b1;
                    w_valid_clr = 1'b1;
                    w_addr_nxt  = w_line_addr;
                    w_miss_inc  = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_WRITE: begin
                w_stall     = 1'b1;
                w_req_valid = 1'b1;
                w_req_we    = 1'b1;
                w_req_addr  = r_addr;
                w_req_data  = r_data;
                if (MemReqReady) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                w_stall     = 1'b1;
                w_req_valid = 1'b1;
                w_req_addr  = r_addr;
                if (MemReqReady) begin
                    w_word_cnt_nxt = '0;
                    w_state_nxt    = S_FILL;
                end
            end
            S_FILL: begin
                w_stall = 1'b1;
                if (MemRespValid) begin
                    w_refill_we    = 1'b1;
                    w_refill_idx   = r_word_cnt;
                    w_word_cnt_nxt = r_word_cnt + c_IDX_W'(1);
                    if (r_word_cnt == c_LAST_IDX) begin
                        w_tag_we    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is held, so combinational IDLE
    // paths cannot leak strobes during reset.
    assign Stall         = ~rst & w_stall;
    assign ValidClr      = ~rst & w_valid_clr;
    assign RefillWE      = ~rst & w_refill_we;
    assign RefillWordIdx = rst ? '0 : w_refill_idx;
    assign TagWE         = ~rst & w_tag_we;
    assign MemReqValid   = ~rst & w_req_valid;
    assign MemReqWE      = ~rst & w_req_we;
    assign MemReqAddr    = rst ? '0 : w_req_addr;
    assign MemReqData    = rst ? '0 : w_req_data;
    assign MissCount     = rst ? '0 : r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_miss_ctrl
// Brief    : Directed bench for dcache_miss_ctrl with a transaction-level
//            model checked every cycle plus hand-computed scenario totals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_miss_ctrl;

    localparam int W  = 4;
    localparam int AW = 32;

    localparam int K_NONE  = 0;   // no transaction outstanding
    localparam int K_STORE = 1;   // store waiting for acceptance
    localparam int K_LINE  = 2;   // line read waiting for acceptance
    localparam int K_WORDS = 3;   // receiving refill words
    localparam int K_LAST  = 4;   // line complete, one quiet cycle

    logic          clk = 1'b0;
    logic          rst;
    logic          MemReadM, MemWriteM, HitM;
    logic [AW-1:0] AddrM;
    logic [31:0]   WriteDataM;
    logic          Stall, ValidClr, RefillWE, TagWE;
    logic [1:0]    RefillWordIdx;
    logic          MemReqValid, MemReqReady, MemReqWE, MemRespValid;
    logic [AW-1:0] MemReqAddr;
    logic [31:0]   MemReqData, MissCount;

    dcache_miss_ctrl #(.WORDS_PER_LINE(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .AddrM(AddrM), .WriteDataM(WriteDataM), .HitM(HitM), .Stall(Stall),
        .ValidClr(ValidClr), .RefillWE(RefillWE), .RefillWordIdx(RefillWordIdx),
        .TagWE(TagWE), .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
        .MemReqWE(MemReqWE), .MemReqAddr(MemReqAddr), .MemReqData(MemReqData),
        .MemRespValid(MemRespValid), .MissCount(MissCount)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model of the outstanding transaction.
    int          m_kind  = K_NONE;
    int          m_words = 0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_miss  = '0;

    // Running totals observed on the DUT outputs.
    int          tot_stall = 0, tot_rwe = 0, tot_tag = 0, tot_vclr = 0;
    int          tot_req = 0, tot_wreq = 0;
    logic [3:0]  rwe_mask = '0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;

    int s_stall, s_rwe, s_tag, s_vclr, s_req, s_wreq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic snap();
        s_stall = tot_stall; s_rwe = tot_rwe; s_tag = tot_tag;
        s_vclr = tot_vclr; s_req = tot_req; s_wreq = tot_wreq;
        rwe_mask = '0;
    endtask

    // One clock cycle: check mid-cycle against the model, advance the
    // model with the inputs the next edge will sample, then step.
    task automatic cyc();
        logic        e_stall, e_vclr, e_rwe, e_tag, e_valid, e_we;
        logic [31:0] e_idx, e_addr, e_data;
        int          n_kind, n_words;
        logic [31:0] n_addr, n_data, n_miss;
        @(negedge clk);
        e_stall = 0; e_vclr = 0; e_rwe = 0; e_tag = 0; e_valid = 0; e_we = 0;
        e_idx = 0; e_addr = 0; e_data = 0;
        n_kind = m_kind; n_words = m_words; n_addr = m_addr; n_data = m_data;
        n_miss = m_miss;
        if (rst) begin
            n_kind = K_NONE; n_words = 0; n_miss = 0; n_addr = 0; n_data = 0;
        end else begin
            case (m_kind)
                K_NONE: begin
                    if (MemWriteM) begin
                        e_valid = 1; e_we = 1; e_addr = AddrM; e_data = WriteDataM;
                        e_stall = !MemReqReady;
                        if (!MemReqReady) begin
                            n_kind = K_STORE; n_addr = AddrM; n_data = WriteDataM;
                        end
                    end else if (MemReadM && !HitM) begin
                        e_stall = 1; e_vclr = 1;
                        n_kind = K_LINE;
                        n_addr = AddrM & ~32'(W * 4 - 1);
                        n_miss = m_miss + 1;
                    end
                end
                K_STORE: begin
                    e_stall = 1; e_valid = 1; e_we = 1; e_addr = m_addr; e_data = m_data;
                    if (MemReqReady) n_kind = K_NONE;
                end
                K_LINE: begin
                    e_stall = 1; e_valid = 1; e_we = 0; e_addr = m_addr;
                    if (MemReqReady) begin
                        n_kind = K_WORDS; n_words = 0;
                    end
                end
                K_WORDS: begin
                    e_stall = 1;
                    if (MemRespValid) begin
                        e_rwe = 1; e_idx = 32'(m_words); e_tag = (m_words == W - 1);
                        n_words = m_words + 1;
                        if (m_words == W - 1) n_kind = K_LAST;
                    end
                end
                default: n_kind = K_NONE;
            endcase
        end
        chk("Stall", {31'd0, Stall}, {31'd0, e_stall});
        chk("ValidClr", {31'd0, ValidClr}, {31'd0, e_vclr});
        chk("RefillWE", {31'd0, RefillWE}, {31'd0, e_rwe});
        chk("TagWE", {31'd0, TagWE}, {31'd0, e_tag});
        chk("MemReqValid", {31'd0, MemReqValid}, {31'd0, e_valid});
        chk("MissCount", MissCount, rst ? 32'd0 : m_miss);
        if (e_rwe) chk("RefillWordIdx", {30'd0, RefillWordIdx}, e_idx);
        if (e_valid) begin
            chk("MemReqWE", {31'd0, MemReqWE}, {31'd0, e_we});
            chk("MemReqAddr", MemReqAddr, e_addr);
            if (e_we) chk("MemReqData", MemReqData, e_data);
        end
        if (Stall) tot_stall++;
        if (RefillWE) begin
            tot_rwe++;
            rwe_mask[RefillWordIdx] = 1'b1;
        end
        if (TagWE) tot_tag++;
        if (ValidClr) tot_vclr++;
        if (MemReqValid) begin
            tot_req++;
            if (MemReqWE) begin
                tot_wreq++; last_wr_addr = MemReqAddr; last_wr_data = MemReqData;
            end else begin
                last_rd_addr = MemReqAddr;
            end
        end
        m_kind = n_kind; m_words = n_words; m_addr = n_addr; m_data = n_data;
        m_miss = n_miss;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; MemReadM = 0; MemWriteM = 0; HitM = 0; AddrM = 0; WriteDataM = 0;
        MemReqReady = 0; MemRespValid = 0;

        // Reset
        cyc(); cyc();
        rst = 0;
        chk("reset_misscount", MissCount, 32'd0);
        chk("reset_stall", {31'd0, Stall}, 32'd0);

        // Load hit
        snap();
        MemReadM = 1; HitM = 1; AddrM = 32'h40;
        cyc();
        MemReadM = 0; HitM = 0;
        chk("hit_stall_cycles", 32'(tot_stall - s_stall), 32'd0);
        chk("hit_requests", 32'(tot_req - s_req), 32'd0);

        // Load miss, ready high, back-to-back words
        snap();
        MemReadM = 1; HitM = 0; AddrM = 32'h0000_1234; MemReqReady = 1;
        cyc();                          // miss detected
        cyc();                          // line request
        MemRespValid = 1;
        repeat (W) cyc();               // four words
        MemRespValid = 0; HitM = 1;
        cyc();                          // quiet cycle, array now hits
        MemReadM = 0; HitM = 0;
        cyc();
        chk("miss_stall_cycles", 32'(tot_stall - s_stall), 32'd6);
        chk("miss_refill_pulses", 32'(tot_rwe - s_rwe), 32'd4);
        chk("miss_refill_indices", {28'd0, rwe_mask}, 32'hF);
        chk("miss_tagwe_pulses", 32'(tot_tag - s_tag), 32'd1);
        chk("miss_validclr", 32'(tot_vclr - s_vclr), 32'd1);
        chk("miss_line_addr", last_rd_addr, 32'h0000_1230);
        chk("miss_count_1", MissCount, 32'd1);

        // Store with ready low for 3 cycles; inputs wander while stalled
        snap();
        MemWriteM = 1; AddrM = 32'h100; WriteDataM = 32'hDEADBEEF; MemReqReady = 0;
        cyc();
        AddrM = 32'hFFF0; WriteDataM = 32'h1234_5678;
        cyc(); cyc();
        MemReqReady = 1;
        cyc();
        MemWriteM = 0; AddrM = 0; WriteDataM = 0;
        cyc();
        chk("store_stall_cycles", 32'(tot_stall - s_stall), 32'd4);
        chk("store_addr", last_wr_addr, 32'h100);
        chk("store_data", last_wr_data, 32'hDEADBEEF);
        chk("store_validclr", 32'(tot_vclr - s_vclr), 32'd0);
        chk("store_misscount", MissCount, 32'd1);

        // Read and write together on a miss: behaves as a store
        snap();
        MemReadM = 1; MemWriteM = 1; HitM = 0; AddrM = 32'h200; WriteDataM = 32'hA5A5_A5A5;
        cyc();
        MemReadM = 0; MemWriteM = 0;
        cyc();
        chk("rw_write_requests", 32'(tot_wreq - s_wreq), 32'd1);
        chk("rw_stall_cycles", 32'(tot_stall - s_stall), 32'd0);
        chk("rw_refill_pulses", 32'(tot_rwe - s_rwe), 32'd0);
        chk("rw_misscount", MissCount, 32'd1);

        // Gapped responses with strays in IDLE and REQ
        MemRespValid = 1;
        cyc();
        MemRespValid = 0;
        snap();
        MemReadM = 1; HitM = 0; AddrM = 32'h0000_2008; MemReqReady = 1;
        cyc();
        MemReqReady = 0; MemRespValid = 1;
        cyc();
        MemRespValid = 0; MemReqReady = 1;
        cyc();
        MemReqReady = 0;
        for (int k = 0; k < 10; k++) begin
            MemRespValid = (k % 3 == 0);
            cyc();
        end
        MemRespValid = 0; HitM = 1;
        cyc();
        MemReadM = 0; HitM = 0;
        cyc();
        chk("gap_refill_pulses", 32'(tot_rwe - s_rwe), 32'd4);
        chk("gap_refill_indices", {28'd0, rwe_mask}, 32'hF);
        chk("gap_tagwe_pulses", 32'(tot_tag - s_tag), 32'd1);
        chk("gap_stall_cycles", 32'(tot_stall - s_stall), 32'd13);
        chk("gap_line_addr", last_rd_addr, 32'h0000_2000);
        chk("gap_misscount", MissCount, 32'd2);

        // Reset after word 1 of 4
        snap();
        MemReadM = 1; HitM = 0; AddrM = 32'h3000; MemReqReady = 1;
        cyc(); cyc();
        MemRespValid = 1;
        cyc(); cyc();
        rst = 1;
        cyc(); cyc();
        rst = 0; MemRespValid = 0; MemReadM = 0;
        cyc();
        chk("rst_tagwe_pulses", 32'(tot_tag - s_tag), 32'd0);
        chk("rst_refill_pulses", 32'(tot_rwe - s_rwe), 32'd2);
        chk("rst_stall_cycles", 32'(tot_stall - s_stall), 32'd4);
        chk("rst_misscount", MissCount, 32'd0);

        // Back in IDLE: an accepted store needs no stall
        snap();
        MemWriteM = 1; AddrM = 32'h44; WriteDataM = 32'h0BAD_F00D; MemReqReady = 1;
        cyc();
        MemWriteM = 0;
        cyc();
        chk("post_rst_store_stall", 32'(tot_stall - s_stall), 32'd0);
        chk("post_rst_store_addr", last_wr_addr, 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
